uart_mmio: RTL and testbench



---
 rtl/uart_mmio.sv | 233 +++++++++++++++++++++++
 tb/tb_uart_mmio.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio.sv
// Memory-mapped full-duplex UART: TX FIFO plus frame serialiser, synchronised mid-bit
// RX deserialiser with a one-byte holding register, runtime 16-bit baud divisor.
module uart_mmio #(
  parameter int unsigned DIV_DEFAULT = 104,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned PARITY_EN   = 0,
  parameter int unsigned PARITY_ODD  = 0,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       writeEnable,
  input  logic       readEnable,
  input  logic [1:0] regSelect,
  input  logic [7:0] writeData,
  input  logic       rx,
  output logic       tx,
  output logic [7:0] Data
);
  localparam int CW = $clog2(FIFO_DEPTH);
  localparam int NW = CW + 1;
  localparam logic PAR_ODD = (PARITY_ODD != 0);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  // Bus: a write strobe takes effect on the posedge where it is sampled high; reads are
  // a pure combinational mux, and readEnable only matters at DATA, where it consumes rx_valid.
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [CW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NW-1:0] count_q, count_d;
  logic [15:0] div_q, div_d, div_eff;
  logic fifo_full, fifo_empty, push, pop;

  state_e tx_state_q, tx_state_d;
  logic [15:0] tdiv_q, tdiv_d, tcnt_q, tcnt_d;
  logic [2:0] tbit_q, tbit_d;
  logic [DATA_BITS-1:0] tshift_q, tshift_d, fifo_head;
  logic tpar_q, tpar_d, tx_q, tx_d, tx_tick;

  state_e rx_state_q, rx_state_d;
  logic rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d;
  logic [15:0] rdiv_q, rdiv_d, rcnt_q, rcnt_d;
  logic [2:0] rbit_q, rbit_d;
  logic [DATA_BITS-1:0] rshift_q, rshift_d, rx_buf_q, rx_buf_d;
  logic rperr_q, rperr_d, rx_tick, rx_half;
  logic frame_done, set_perr, set_ferr, set_ovr;
  logic rx_valid_q, rx_valid_d, overrun_q, overrun_d;
  logic parity_err_q, parity_err_d, frame_err_q, frame_err_d;
  logic rd_data, valid_eff;
  logic [7:0] clr;

  assign div_eff    = (div_q < 16'd2) ? 16'd2 : div_q;
  assign fifo_full  = (count_q == NW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign fifo_head  = mem_q[rd_ptr_q];
  assign push       = writeEnable && (regSelect == 2'd0) && !fifo_full;
  assign tx_tick    = (tcnt_q == tdiv_q - 16'd1);
  assign rx_tick    = (rcnt_q == rdiv_q - 16'd1);
  assign rx_half    = (rcnt_q == (rdiv_q >> 1) - 16'd1);
  assign tx         = tx_q;

  // TX serialiser; tx is registered from the next-state values so it never glitches.
  always_comb begin
    tx_state_d = tx_state_q;
    tdiv_d     = tdiv_q;
    tcnt_d     = tcnt_q;
    tbit_d     = tbit_q;
    tshift_d   = tshift_q;
    tpar_d     = tpar_q;
    pop        = 1'b0;
    if (tx_state_q == S_IDLE) begin
      if (!fifo_empty) begin
        pop        = 1'b1;
        tshift_d   = fifo_head;
        tpar_d     = (^fifo_head) ^ PAR_ODD;
        tdiv_d     = div_eff;
        tcnt_d     = '0;
        tbit_d     = '0;
        tx_state_d = S_START;
      end
    end else if (!tx_tick) begin
      tcnt_d = tcnt_q + 16'd1;
    end else begin
      tcnt_d = '0;
      case (tx_state_q)
        S_START: begin
          tx_state_d = S_DATA;
          tbit_d     = '0;
        end
        S_DATA: begin
          if (tbit_q == 3'(DATA_BITS - 1)) begin
            tx_state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            tbit_d     = '0;
          end else begin
            tbit_d   = tbit_q + 3'd1;
            tshift_d = tshift_q >> 1;
          end
        end
        S_PARITY: begin
          tx_state_d = S_STOP;
          tbit_d     = '0;
        end
        S_STOP: begin
          if (tbit_q == 3'(STOP_BITS - 1)) tx_state_d = S_IDLE;
          else                             tbit_d     = tbit_q + 3'd1;
        end
        default: tx_state_d = S_IDLE;
      endcase
    end
    case (tx_state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = tshift_d[0];
      S_PARITY: tx_d = tpar_d;
      default:  tx_d = 1'b1;
    endcase
  end

  // RX deserialiser; samples are taken half a bit after the first low sample, then every bit.
  always_comb begin
    rx_meta_d  = rx;
    rx_sync_d  = rx_meta_q;
    rx_state_d = rx_state_q;
    rdiv_d     = rdiv_q;
    rcnt_d     = rcnt_q;
    rbit_d     = rbit_q;
    rshift_d   = rshift_q;
    rperr_d    = rperr_q;
    frame_done = 1'b0;
    set_perr   = 1'b0;
    set_ferr   = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        if (!rx_sync_q) begin
          rx_state_d = S_START;
          rdiv_d     = div_eff;
          rcnt_d     = '0;
          rperr_d    = 1'b0;
        end
      end
      S_START: begin
        if (rx_half) begin
          rcnt_d     = '0;
          rbit_d     = '0;
          rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
        end else rcnt_d = rcnt_q + 16'd1;
      end
      S_DATA: begin
        if (rx_tick) begin
          rcnt_d   = '0;
          rshift_d = {rx_sync_q, rshift_q[DATA_BITS-1:1]};
          if (rbit_q == 3'(DATA_BITS - 1)) begin
            rx_state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            rbit_d     = '0;
          end else rbit_d = rbit_q + 3'd1;
        end else rcnt_d = rcnt_q + 16'd1;
      end
      S_PARITY: begin
        if (rx_tick) begin
          rcnt_d     = '0;
          rperr_d    = (rx_sync_q != ((^rshift_q) ^ PAR_ODD));
          rx_state_d = S_STOP;
        end else rcnt_d = rcnt_q + 16'd1;
      end
      S_STOP: begin
        if (rx_tick) begin
          frame_done = 1'b1;
          set_ferr   = !rx_sync_q;
          set_perr   = rperr_q;
          rx_state_d = S_IDLE;
        end else rcnt_d = rcnt_q + 16'd1;
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // Register file; a flag set on the same edge as its clear wins.
  always_comb begin
    rd_data   = readEnable && (regSelect == 2'd0);
    valid_eff = rx_valid_q && !rd_data;
    clr       = (writeEnable && (regSelect == 2'd1)) ? writeData : 8'h00;
    set_ovr   = frame_done && valid_eff;
    rx_valid_d = valid_eff;
    rx_buf_d   = rx_buf_q;
    if (frame_done && !valid_eff) begin
      rx_valid_d = 1'b1;
      rx_buf_d   = rshift_q;
    end
    overrun_d    = (overrun_q    & ~clr[3]) | set_ovr;
    parity_err_d = (parity_err_q & ~clr[4]) | set_perr;
    frame_err_d  = (frame_err_q  & ~clr[5]) | set_ferr;
    div_d = div_q;
    if (writeEnable && (regSelect == 2'd2)) div_d[7:0]  = writeData;
    if (writeEnable && (regSelect == 2'd3)) div_d[15:8] = writeData;
    wr_ptr_d = wr_ptr_q + CW'(push);
    rd_ptr_d = rd_ptr_q + CW'(pop);
    count_d  = count_q + NW'(push) - NW'(pop);
    case (regSelect)
      2'd0:    Data = 8'(rx_buf_q);
      2'd1:    Data = {1'b0, (tx_state_q != S_IDLE), frame_err_q, parity_err_q,
                       overrun_q, rx_valid_q, fifo_empty, fifo_full};
      2'd2:    Data = div_q[7:0];
      default: Data = div_q[15:8];
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= writeData[DATA_BITS-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;  rd_ptr_q <= '0;  count_q <= '0;
      div_q <= 16'(DIV_DEFAULT);
      tx_state_q <= S_IDLE;  tdiv_q <= 16'd2;  tcnt_q <= '0;  tbit_q <= '0;
      tshift_q <= '0;  tpar_q <= 1'b0;  tx_q <= 1'b1;
      rx_meta_q <= 1'b1;  rx_sync_q <= 1'b1;
      rx_state_q <= S_IDLE;  rdiv_q <= 16'd2;  rcnt_q <= '0;  rbit_q <= '0;
      rshift_q <= '0;  rperr_q <= 1'b0;  rx_buf_q <= '0;
      rx_valid_q <= 1'b0;  overrun_q <= 1'b0;  parity_err_q <= 1'b0;  frame_err_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;  rd_ptr_q <= rd_ptr_d;  count_q <= count_d;
      div_q <= div_d;
      tx_state_q <= tx_state_d;  tdiv_q <= tdiv_d;  tcnt_q <= tcnt_d;  tbit_q <= tbit_d;
      tshift_q <= tshift_d;  tpar_q <= tpar_d;  tx_q <= tx_d;
      rx_meta_q <= rx_meta_d;  rx_sync_q <= rx_sync_d;
      rx_state_q <= rx_state_d;  rdiv_q <= rdiv_d;  rcnt_q <= rcnt_d;  rbit_q <= rbit_d;
      rshift_q <= rshift_d;  rperr_q <= rperr_d;  rx_buf_q <= rx_buf_d;
      rx_valid_q <= rx_valid_d;  overrun_q <= overrun_d;
      parity_err_q <= parity_err_d;  frame_err_q <= frame_err_d;
    end
  end
endmodule

// File: tb/tb_uart_mmio.sv
// Bench for uart_mmio: instance A is 8N1 for TX/FIFO/reset checks, instance B has even
// parity and a selectable rx source (its own tx, or a bit-banged line) for RX checks.
module tb_uart_mmio;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, we, re, sel, loop_en, rx_drv, rx_b, tx_a, tx_b;
  logic [1:0] rs;
  logic [7:0] wd, data_a, data_b;
  int pass_cnt = 0, total_cnt = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;
  assign rx_b = loop_en ? tx_b : rx_drv;

  uart_mmio u_a (
    .clk(clk), .reset(reset), .writeEnable(we & ~sel), .readEnable(re & ~sel),
    .regSelect(rs), .writeData(wd), .rx(1'b1), .tx(tx_a), .Data(data_a)
  );
  uart_mmio #(.PARITY_EN(1), .PARITY_ODD(0)) u_b (
    .clk(clk), .reset(reset), .writeEnable(we & sel), .readEnable(re & sel),
    .regSelect(rs), .writeData(wd), .rx(rx_b), .tx(tx_b), .Data(data_b)
  );

  typedef struct {
    logic [1:0] addr;
    logic       wr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } reg_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
  endtask

  function automatic logic txs(input bit s);
    return s ? tx_b : tx_a;
  endfunction

  task automatic bus_write(input bit s, input logic [1:0] a, input logic [7:0] d);
    @(negedge clk); sel = s; rs = a; wd = d; we = 1'b1;
    @(negedge clk); we = 1'b0;
  endtask

  task automatic bus_read(input bit s, input logic [1:0] a, input bit consume,
                          output logic [7:0] d);
    @(negedge clk); sel = s; rs = a; re = consume;
    #1 d = s ? data_b : data_a;
    @(negedge clk); re = 1'b0;
  endtask

  task automatic read_check(input bit s, input logic [1:0] a, input bit consume,
                            input string name, input logic [7:0] exp);
    logic [7:0] d;
    bus_read(s, a, consume, d);
    check(name, d, exp);
  endtask

  // Waits for a start bit, then samples every bit at its centre; busy holds status bit6.
  task automatic capture_frame(input bit s, input int div, input int nbits,
                               output logic [15:0] bits, output logic [15:0] busy,
                               output int start_cyc, output bit ok);
    int t;
    logic [7:0] d;
    t = 0; bits = '0; busy = '0; ok = 1'b0;
    while (txs(s) !== 1'b0 && t < 4000) begin @(negedge clk); t++; end
    start_cyc = cyc;
    if (t >= 4000) return;
    repeat (div / 2) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      bits[i] = txs(s);
      d = s ? data_b : data_a;
      busy[i] = d[6];
      if (i < nbits - 1) repeat (div) @(negedge clk);
    end
    ok = 1'b1;
  endtask

  task automatic low_run(input bit s, output int n);
    int t;
    t = 0; n = 0;
    while (txs(s) !== 1'b0 && t < 4000) begin @(negedge clk); t++; end
    while (txs(s) === 1'b0 && n < 5000) begin @(negedge clk); n++; end
  endtask

  task automatic low_count(input bit s, input int ncyc, output int n);
    n = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (txs(s) === 1'b0) n++;
    end
  endtask

  // Bit-bangs one 8E-style frame into instance B at div=16.
  task automatic send_frame(input logic [7:0] data, input bit flip, input bit stop_val);
    @(negedge clk); rx_drv = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = data[i];
      repeat (16) @(negedge clk);
    end
    rx_drv = (^data) ^ flip;
    repeat (16) @(negedge clk);
    rx_drv = stop_val;
    repeat (16) @(negedge clk);
    rx_drv = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reg_vec_t vecs[8];
    logic [15:0] bits, busy;
    int sc, prev_sc, n, t;
    bit ok;

    vecs[0] = '{2'd1, 1'b0, 8'h00, 8'h02};
    vecs[1] = '{2'd0, 1'b0, 8'h00, 8'h00};
    vecs[2] = '{2'd2, 1'b0, 8'h00, 8'h68};
    vecs[3] = '{2'd3, 1'b0, 8'h00, 8'h00};
    vecs[4] = '{2'd3, 1'b1, 8'h12, 8'h12};
    vecs[5] = '{2'd2, 1'b1, 8'h34, 8'h34};
    vecs[6] = '{2'd3, 1'b1, 8'h00, 8'h00};
    vecs[7] = '{2'd2, 1'b1, 8'h10, 8'h10};

    reset = 1'b1; we = 1'b0; re = 1'b0; sel = 1'b0; rs = 2'd0; wd = 8'h00;
    loop_en = 1'b0; rx_drv = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_tx_a", tx_a, 1'b1);
    check("reset_tx_b", tx_b, 1'b1);

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].wr) bus_write(1'b0, vecs[i].addr, vecs[i].wdata);
      read_check(1'b0, vecs[i].addr, 1'b0, $sformatf("reg_vec%0d", i), vecs[i].exp);
    end

    // Single 8N1 frame at div=16, with busy observed at every bit centre.
    bus_write(1'b0, 2'd0, 8'h48);
    rs = 2'd1;
    capture_frame(1'b0, 16, 10, bits, busy, sc, ok);
    check("tx48_found", ok, 1'b1);
    check("tx48_frame", bits, {6'b0, 1'b1, 8'h48, 1'b0});
    check("tx48_busy", busy, 16'h03FF);
    repeat (20) @(negedge clk);
    read_check(1'b0, 2'd1, 1'b0, "tx48_done_status", 8'h02);
    bus_write(1'b0, 2'd0, 8'h48);
    low_run(1'b0, n);
    check("tx48_low_cycles", n, 64);
    repeat (120) @(negedge clk);

    // FIFO: a lead 0xFF occupies the serialiser, then six back-to-back writes.
    bus_write(1'b0, 2'd0, 8'hFF);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); sel = 1'b0; rs = 2'd0; wd = 8'h41 + 8'(i); we = 1'b1;
    end
    @(negedge clk); we = 1'b0;
    read_check(1'b0, 2'd1, 1'b0, "fifo_full_status", 8'h41);
    t = 0;
    while (tx_a !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    check("fifo_lead_start_end", t < 100, 1'b1);
    prev_sc = 0;
    for (int i = 0; i < 4; i++) begin
      capture_frame(1'b0, 16, 10, bits, busy, sc, ok);
      check($sformatf("fifo_frame%0d", i), bits, {6'b0, 1'b1, 8'h41 + 8'(i), 1'b0});
      if (i > 0) check($sformatf("fifo_gap%0d", i), (sc - prev_sc >= 160) && (sc - prev_sc <= 161), 1'b1);
      prev_sc = sc;
    end
    low_count(1'b0, 400, n);
    check("fifo_dropped_no_frame", n, 0);
    read_check(1'b0, 2'd1, 1'b0, "fifo_drained_status", 8'h02);

    // Instance B: div=16, loopback of 0x55 with even parity.
    bus_write(1'b1, 2'd2, 8'h10);
    read_check(1'b1, 2'd1, 1'b0, "b_reset_status", 8'h02);
    loop_en = 1'b1;
    bus_write(1'b1, 2'd0, 8'h55);
    @(negedge clk); sel = 1'b1; rs = 2'd1;
    t = 0;
    while (data_b[2] !== 1'b1 && t < 2000) begin @(negedge clk); t++; end
    check("loop_rx_valid_seen", t < 2000, 1'b1);
    repeat (40) @(negedge clk);
    loop_en = 1'b0;
    read_check(1'b1, 2'd1, 1'b0, "loop_status", 8'h06);
    read_check(1'b1, 2'd0, 1'b1, "loop_data", 8'h55);
    read_check(1'b1, 2'd1, 1'b0, "loop_consumed_status", 8'h02);

    // Flipped parity bit, then clearing parity_err via STATUS.
    send_frame(8'h3C, 1'b1, 1'b1);
    read_check(1'b1, 2'd1, 1'b0, "perr_status", 8'h16);
    read_check(1'b1, 2'd0, 1'b1, "perr_data", 8'h3C);
    read_check(1'b1, 2'd1, 1'b0, "perr_after_read", 8'h12);
    bus_write(1'b1, 2'd1, 8'h10);
    read_check(1'b1, 2'd1, 1'b0, "perr_cleared", 8'h02);

    // Overrun keeps the first byte.
    send_frame(8'hA5, 1'b0, 1'b1);
    send_frame(8'h3C, 1'b0, 1'b1);
    read_check(1'b1, 2'd1, 1'b0, "ovr_status", 8'h0E);
    read_check(1'b1, 2'd0, 1'b1, "ovr_data", 8'hA5);
    read_check(1'b1, 2'd1, 1'b0, "ovr_after_read", 8'h0A);

    // Short low glitch of div/4 must not produce a byte.
    @(negedge clk); rx_drv = 1'b0;
    repeat (4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    read_check(1'b1, 2'd1, 1'b0, "glitch_status", 8'h0A);
    bus_write(1'b1, 2'd1, 8'h08);
    read_check(1'b1, 2'd1, 1'b0, "ovr_cleared", 8'h02);

    // Stop bit driven low.
    send_frame(8'h81, 1'b0, 1'b0);
    read_check(1'b1, 2'd1, 1'b0, "ferr_status", 8'h26);
    read_check(1'b1, 2'd0, 1'b1, "ferr_data", 8'h81);

    // Reset in the middle of the third data bit of a frame with a second byte queued.
    bus_write(1'b0, 2'd0, 8'h33);
    bus_write(1'b0, 2'd0, 8'h77);
    repeat (52) @(negedge clk);
    check("pre_reset_busy_line", tx_a, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("reset_mid_frame_tx", tx_a, 1'b1);
    reset = 1'b0;
    read_check(1'b0, 2'd1, 1'b0, "reset_mid_status", 8'h02);
    read_check(1'b0, 2'd2, 1'b0, "reset_mid_div_lo", 8'h68);
    read_check(1'b0, 2'd3, 1'b0, "reset_mid_div_hi", 8'h00);
    low_count(1'b0, 300, n);
    check("reset_queue_lost", n, 0);
    bus_write(1'b0, 2'd0, 8'h01);
    capture_frame(1'b0, 104, 10, bits, busy, sc, ok);
    check("post_reset_frame", bits, {6'b0, 1'b1, 8'h01, 1'b0});
    repeat (60) @(negedge clk);
    bus_write(1'b0, 2'd0, 8'h01);
    low_run(1'b0, n);
    check("post_reset_start_cycles", n, 104);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
